reg_status_file: RTL
====================

// Module: reg_status_file
// PURPOSE
// - Architectural register file plus rename-status table for the out-of-order core; the receiving end of
//   the reorder buffer's rename (issue) and commit streams, and responder to its operand lookups.
// - Per register: committed value, busy bit, owning ROB tag. Answers two source lookups per cycle.
//   A busy source returns its ROB tag, so the consumer can wait on the CDB.
// PARAMETERS
// - NREG      32  architectural registers (x0 hardwired zero)
// - TAG_W     4   ROB tag width (16-entry ROB)
// - XLEN      32  data width
// PORTS
// - clk            in   1      clock, posedge
// - rst            in   1      asynchronous, active-high reset
// - rdy            in   1      global enable; low = state holds
// - rename_en      in   1      issue: rename_idx gets a new producer
// - rename_idx     in   5      destination register being renamed
// - rename_tag     in   TAG_W  ROB tag of that producer
// - commit_en      in   1      ROB head retires a register write
// - commit_idx     in   5      destination register
// - commit_val     in   XLEN   committed value
// - commit_tag     in   TAG_W  ROB tag of the retiring entry
// - flush          in   1      mispredict: discard all rename state
// - rs1_addr/rs2_addr      in   5     source lookups
// - rs1_ready/rs2_ready    out  1     1 = value valid
// - rs1_val/rs2_val        out  XLEN  value if ready, else {zero-extend, owning tag}
// BEHAVIOUR
// - Reset (async, any time, incl. mid-stream): all values 0, busy 0, tags 0.
//   Lookups then return ready=1, val=0 for every register.
// - State updates occur at posedge only when rdy=1 and rst=0; with rdy=0 nothing changes.
// - x0: never busy, always reads ready=1 val=0. Renames and commits to x0 are ignored.
// - Rename at edge: busy[idx]<=1, tag[idx]<=rename_tag.
// - Commit at edge: value[idx]<=commit_val unconditionally (idx!=0).
//   busy[idx]<=0 only if tag[idx]==commit_tag and the same register is not renamed this cycle.
//   A stale commit (tag mismatch) leaves busy/tag untouched.
// - Rename + commit to the same reg in the same cycle: value written, busy stays 1, tag = rename_tag.
// - Flush at edge: every busy<=0, values kept.
//   Flush overrides a same-cycle rename, which is dropped. A same-cycle commit still writes its value.
// - Lookups: combinational, zero latency.
//   If !busy -> ready=1, val=value.
//   Else if commit_en && commit_idx==addr && commit_tag==tag -> ready=1, val=commit_val (bypass).
//   Else -> ready=0, val={{XLEN-TAG_W{0}},tag}.
// - A lookup never sees a same-cycle rename. Sources resolve before their own destination is renamed
//   (add x1,x1,x2 reads the old x1).
// - Bypass is gated by rdy, because no commit takes effect while rdy=0.
// - No internal FSM beyond per-register state. Tag reuse after ROB wrap is safe: a newer rename always
//   overwrites tag before the older tag commits.
// STRUCTURE
// - defines.v: TAG_W (`RBID), register index width (`RIDX), `True/`False.
// - One sub-module: reg_status_rdport (lookup + commit bypass), instantiated twice.
// - Storage arrays and update logic live in the top.
// TESTING
// - Reset then read x5 -> ready=1 val=0. Assert rst mid-rename -> all busy cleared immediately.
// - Rename x3 tag 7. Next cycle read x3 -> ready=0 val=7.
//   Commit x3 tag 7 val 0xDEAD -> same cycle ready=1 val=0xDEAD (bypass); after edge busy=0.
// - Rename x4 tag 2, then x4 tag 9. Commit x4 tag 2 val 0x11 -> value=0x11, busy=1, read val=9.
// - Same cycle rename x6 tag 5 + commit x6 (old tag 1, val 0x22) -> value 0x22, busy=1, tag 5.
//   Rename/commit x0 -> x0 reads ready=1 val 0.
// - Rename x1..x8 -> flush with rename x9 tag 3 -> all ready, x9 not busy. Old values intact.
// - rdy=0 with rename x2 + commit x7 -> no state change, no bypass. Repeat with rdy=1 -> both applied.

Source files
------------

// File: rtl/reg_status_file_pkg.sv
// rtl/reg_status_file_pkg.sv - shared widths and helpers for the register/status file
package reg_status_file_pkg;

  localparam int NREG   = 32;
  localparam int TAG_W  = 4;
  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // A not-ready source carries its producer tag in the low bits of the value bus.
  function automatic logic [XLEN-1:0] tag_to_val(input logic [TAG_W-1:0] tag);
    return {{(XLEN-TAG_W){1'b0}}, tag};
  endfunction

endpackage

// File: rtl/reg_status_file_rdport.sv
// rtl/reg_status_file_rdport.sv - one source lookup with commit-stream bypass
module reg_status_file_rdport
  import reg_status_file_pkg::*;
(
  input  logic [RIDX_W-1:0] i_addr,
  input  logic              i_busy,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [XLEN-1:0]   i_value,
  input  logic              i_byp_en,
  input  logic [RIDX_W-1:0] i_commit_idx,
  input  logic [TAG_W-1:0]  i_commit_tag,
  input  logic [XLEN-1:0]   i_commit_val,
  output logic              o_ready,
  output logic [XLEN-1:0]   o_val
);

  logic w_byp_hit;

  // Only the commit from the current owner may resolve a busy source.
  assign w_byp_hit = i_byp_en && (i_commit_idx == i_addr) && (i_commit_tag == i_tag);

  always_comb begin
    o_ready = TRUE;
    o_val   = i_value;
    if (i_busy) begin
      if (w_byp_hit) begin
        o_val = i_commit_val;
      end else begin
        o_ready = FALSE;
        o_val   = tag_to_val(i_tag);
      end
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural register values plus rename busy/tag table, two read ports
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rdy,
  input  logic              i_rename_en,
  input  logic [RIDX_W-1:0] i_rename_idx,
  input  logic [TAG_W-1:0]  i_rename_tag,
  input  logic              i_commit_en,
  input  logic [RIDX_W-1:0] i_commit_idx,
  input  logic [XLEN-1:0]   i_commit_val,
  input  logic [TAG_W-1:0]  i_commit_tag,
  input  logic              i_flush,
  input  logic [RIDX_W-1:0] i_rs1_addr,
  input  logic [RIDX_W-1:0] i_rs2_addr,
  output logic              o_rs1_ready,
  output logic [XLEN-1:0]   o_rs1_val,
  output logic              o_rs2_ready,
  output logic [XLEN-1:0]   o_rs2_val
);

  logic [XLEN-1:0]  r_value [NREG];
  logic [TAG_W-1:0] r_tag   [NREG];
  logic             r_busy  [NREG];

  logic w_byp_en;

  assign w_byp_en = i_rdy && i_commit_en;

  // Entry 0 is only ever written by reset, which keeps x0 ready and zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
        r_busy[i]  <= FALSE;
      end
    end else if (i_rdy) begin
      for (int i = 1; i < NREG; i++) begin
        if (i_commit_en && (i_commit_idx == RIDX_W'(i))) begin
          r_value[i] <= i_commit_val;
        end
        if (i_flush) begin
          r_busy[i] <= FALSE;
        end else if (i_rename_en && (i_rename_idx == RIDX_W'(i))) begin
          r_busy[i] <= TRUE;
          r_tag[i]  <= i_rename_tag;
        end else if (i_commit_en && (i_commit_idx == RIDX_W'(i)) && (r_tag[i] == i_commit_tag)) begin
          r_busy[i] <= FALSE;
        end
      end
    end
  end

  reg_status_file_rdport u_rd1 (
    .i_addr       (i_rs1_addr),
    .i_busy       (r_busy[i_rs1_addr]),
    .i_tag        (r_tag[i_rs1_addr]),
    .i_value      (r_value[i_rs1_addr]),
    .i_byp_en     (w_byp_en),
    .i_commit_idx (i_commit_idx),
    .i_commit_tag (i_commit_tag),
    .i_commit_val (i_commit_val),
    .o_ready      (o_rs1_ready),
    .o_val        (o_rs1_val)
  );

  reg_status_file_rdport u_rd2 (
    .i_addr       (i_rs2_addr),
    .i_busy       (r_busy[i_rs2_addr]),
    .i_tag        (r_tag[i_rs2_addr]),
    .i_value      (r_value[i_rs2_addr]),
    .i_byp_en     (w_byp_en),
    .i_commit_idx (i_commit_idx),
    .i_commit_tag (i_commit_tag),
    .i_commit_val (i_commit_val),
    .o_ready      (o_rs2_ready),
    .o_val        (o_rs2_val)
  );

endmodule
